jt12_sh_ram: RTL and testbench

JT12_SH_RAM -- requirements
Module: jt12_sh_ram

---
 rtl/jt12_sh_ram_if.sv | 29 ++
 rtl/jt12_sh_ram.sv | 133 +++++++++++++
 tb/tb_jt12_sh_ram.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/jt12_sh_ram_if.sv
// Bus bundle for jt12_sh_ram: shift control, data in/out and status.
// Save-state signals exist only when JT12_SH_SS_EN is defined.
interface jt12_sh_ram_if #(
    parameter int width = 5,
    parameter int aw    = 5
);
    logic             clk_en;
    logic             clr;
    logic [width-1:0] din;
    logic [width-1:0] drop;
    logic             busy;
    logic [aw-1:0]    slot;
`ifdef JT12_SH_SS_EN
    logic [aw-1:0]    ss_addr;
    logic             ss_wr;
    logic [width-1:0] ss_din;
    logic [width-1:0] ss_dout;

    modport master (output clk_en, clr, din, ss_addr, ss_wr, ss_din,
                    input  drop, busy, slot, ss_dout);
    modport slave  (input  clk_en, clr, din, ss_addr, ss_wr, ss_din,
                    output drop, busy, slot, ss_dout);
`else
    modport master (output clk_en, clr, din,
                    input  drop, busy, slot);
    modport slave  (input  clk_en, clr, din,
                    output drop, busy, slot);
`endif
endinterface

// File: rtl/jt12_sh_ram.sv
// jt12_sh_ram: stages-deep delay line built from a (stages-1)-slot RAM plus a drop register.
// Define JT12_SH_SS_EN to add a save-state access port to the RAM.
module jt12_sh_ram #(
    parameter int               width  = 5,
    parameter int               stages = 32,
    parameter logic [width-1:0] rstval = {width{1'b0}}
)(
    input  logic         clk,
    input  logic         rst_n,
    jt12_sh_ram_if.slave bus
);
    localparam int depth = stages - 1;
    localparam int aw    = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [aw-1:0] last_slot = aw'(depth - 1);
    localparam logic [aw-1:0] one_slot  = aw'(1);
    localparam logic [aw-1:0] zero_slot = {aw{1'b0}};

    typedef enum logic [0:0] { ST_CLEAR = 1'b0, ST_RUN = 1'b1 } state_t;

    state_t           state_r, state_s;
    logic [aw-1:0]    slot_r, slot_s;
    logic [width-1:0] drop_r, drop_s;
    logic             busy_r, busy_s;
    logic             we_s;
    logic [width-1:0] wdata_s;
    logic [width-1:0] mem_r [0:depth-1];

    // Next-state: clr overrides everything, CLEAR sweeps rstval, RUN shifts on clk_en
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        drop_s  = drop_r;
        busy_s  = busy_r;
        we_s    = 1'b0;
        wdata_s = rstval;
        if (bus.clr) begin
            state_s = ST_CLEAR;
            slot_s  = zero_slot;
            drop_s  = rstval;
            busy_s  = 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    we_s    = 1'b1;
                    wdata_s = rstval;
                    drop_s  = rstval;
                    if (slot_r == last_slot) begin
                        state_s = ST_RUN;
                        slot_s  = zero_slot;
                        busy_s  = 1'b0;
                    end else begin
                        slot_s  = slot_r + one_slot;
                        busy_s  = 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_s = 1'b0;
                    if (bus.clk_en) begin
                        we_s    = 1'b1;
                        wdata_s = bus.din;
                        drop_s  = mem_r[slot_r];
                        slot_s  = (slot_r == last_slot) ? zero_slot : slot_r + one_slot;
                    end else begin
                        we_s    = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_CLEAR;
                    slot_s  = zero_slot;
                    drop_s  = rstval;
                    busy_s  = 1'b1;
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
            slot_r  <= zero_slot;
            drop_r  <= rstval;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            drop_r  <= drop_s;
            busy_r  <= busy_s;
        end
    end

`ifdef JT12_SH_SS_EN
    logic             ss_we_s;
    logic             ss_in_range_s;
    logic [width-1:0] ss_dout_r;

    assign ss_in_range_s = (bus.ss_addr <= last_slot);
    assign ss_we_s       = bus.ss_wr && ss_in_range_s && !bus.clr && (state_r == ST_RUN);

    // Save-state read port, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_dout_r <= rstval;
        end else begin
            ss_dout_r <= ss_in_range_s ? mem_r[bus.ss_addr] : rstval;
        end
    end

    assign bus.ss_dout = ss_dout_r;

    // Storage; the shift write comes last so it wins an address collision
    always_ff @(posedge clk) begin
        if (ss_we_s) begin
            mem_r[bus.ss_addr] <= bus.ss_din;
        end
        if (we_s) begin
            mem_r[slot_r] <= wdata_s;
        end
    end
`else
    // Storage: single write port addressed by the slot pointer
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[slot_r] <= wdata_s;
        end
    end
`endif

    assign bus.drop = drop_r;
    assign bus.busy = busy_r;
    assign bus.slot = slot_r;

endmodule

// File: tb/tb_jt12_sh_ram.sv
// Directed bench for jt12_sh_ram (width=5, stages=4, rstval=0): vector table plus
// hand-written reset and save-state sequences.
module tb_jt12_sh_ram;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    jt12_sh_ram_if #(.width(5), .aw(2)) bus ();

    jt12_sh_ram #(.width(5), .stages(4), .rstval(5'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic [4:0] din;
        logic [4:0] drop;
        logic       busy;
        logic [1:0] slot;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic c, input logic [4:0] d,
                       input logic [4:0] drp, input logic bsy, input logic [1:0] sl);
        vec_t v;
        v.en = en; v.clr = c; v.din = d; v.drop = drp; v.busy = bsy; v.slot = sl;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic en, input logic c, input logic [4:0] d);
        bus.clk_en = en;
        bus.clr    = c;
        bus.din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input int drp, input int bsy, input int sl);
        chk({tag, " drop"}, int'(bus.drop), drp);
        chk({tag, " busy"}, int'(bus.busy), bsy);
        chk({tag, " slot"}, int'(bus.slot), sl);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.clk_en = 1'b0;
        bus.clr    = 1'b0;
        bus.din    = 5'd0;
`ifdef JT12_SH_SS_EN
        bus.ss_addr = 2'd0;
        bus.ss_wr   = 1'b0;
        bus.ss_din  = 5'd0;
`endif

        // sweep with clk_en low: busy for 3 cycles
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 2'd1);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 2'd2);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 2'd0);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 2'd0);
        // enables every cycle
        add(1'b1, 1'b0, 5'd1,  5'd0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd2,  5'd0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd3,  5'd0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd4,  5'd1, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd5,  5'd2, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd6,  5'd3, 1'b0, 2'd0);
        // enables every other cycle
        add(1'b0, 1'b0, 5'd31, 5'd3, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd1,  5'd4, 1'b0, 2'd1);
        add(1'b0, 1'b0, 5'd31, 5'd4, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd2,  5'd5, 1'b0, 2'd2);
        add(1'b0, 1'b0, 5'd31, 5'd5, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd3,  5'd6, 1'b0, 2'd0);
        add(1'b0, 1'b0, 5'd31, 5'd6, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd4,  5'd1, 1'b0, 2'd1);
        add(1'b0, 1'b0, 5'd31, 5'd1, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd5,  5'd2, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd6,  5'd3, 1'b0, 2'd0);
        // fill with 7, then clr together with clk_en
        add(1'b1, 1'b0, 5'd7,  5'd4, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd7,  5'd5, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd7,  5'd6, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd7,  5'd7, 1'b0, 2'd1);
        add(1'b1, 1'b1, 5'd9,  5'd0, 1'b1, 2'd0);
        add(1'b1, 1'b0, 5'd9,  5'd0, 1'b1, 2'd1);
        add(1'b1, 1'b0, 5'd9,  5'd0, 1'b1, 2'd2);
        add(1'b1, 1'b0, 5'd9,  5'd0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd10, 5'd0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 5'd11, 5'd0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 5'd12, 5'd0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd13, 5'd10, 1'b0, 2'd1);
        // clr held, released, then re-asserted mid-sweep
        add(1'b0, 1'b1, 5'd0,  5'd0, 1'b1, 2'd0);
        add(1'b1, 1'b1, 5'd1,  5'd0, 1'b1, 2'd0);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 2'd1);
        add(1'b0, 1'b1, 5'd0,  5'd0, 1'b1, 2'd0);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 2'd1);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b1, 2'd2);
        add(1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 5'd3,  5'd0, 1'b0, 2'd1);

        // reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        chk3("reset", 0, 1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].en, vq[i].clr, vq[i].din);
            chk3($sformatf("v%0d", i), int'(vq[i].drop), int'(vq[i].busy), int'(vq[i].slot));
        end

        // mid-run reset: RAM holds {3,0,0} at slot 1
        step(1'b1, 1'b0, 5'd8);
        step(1'b1, 1'b0, 5'd9);
        step(1'b1, 1'b0, 5'd1);
        chk3("prerst", 3, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk3("rst_run", 0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // mid-sweep reset
        step(1'b0, 1'b0, 5'd0);
        chk3("sweep1", 0, 1, 1);
        #2 rst_n = 1'b0;
        #1 chk3("rst_sweep", 0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 5'd0);
        chk3("rs1", 0, 1, 1);
        step(1'b0, 1'b0, 5'd0);
        chk3("rs2", 0, 1, 2);
        step(1'b0, 1'b0, 5'd0);
        chk3("rs3", 0, 0, 0);
        // stale RAM contents must not leak out
        step(1'b1, 1'b0, 5'd5);
        chk("post_e1 drop", int'(bus.drop), 0);
        step(1'b1, 1'b0, 5'd6);
        chk("post_e2 drop", int'(bus.drop), 0);
        step(1'b1, 1'b0, 5'd7);
        chk("post_e3 drop", int'(bus.drop), 0);
        step(1'b1, 1'b0, 5'd0);
        chk3("post_e4", 5, 0, 1);

`ifdef JT12_SH_SS_EN
        bus.ss_addr = 2'd1;
        bus.ss_din  = 5'd9;
        bus.ss_wr   = 1'b1;
        step(1'b0, 1'b0, 5'd0);
        bus.ss_wr   = 1'b0;
        step(1'b0, 1'b0, 5'd0);
        chk("ss_rd", int'(bus.ss_dout), 9);
        // slot is 1: shift write collides with save-state write
        bus.ss_wr   = 1'b1;
        step(1'b1, 1'b0, 5'd4);
        bus.ss_wr   = 1'b0;
        step(1'b0, 1'b0, 5'd0);
        chk("ss_coll", int'(bus.ss_dout), 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
